// File: rtl/node_pkg.sv
// Shared definitions for the node sequencer: FSM state encoding, default
// data width, the layer-1 size constants and an address-width helper.
package node_pkg;

   // Sequencer states, in the order a layer pass walks through them
   typedef enum logic [2:0] {
      IDLE,
      LOAD_B,
      STREAM,
      DRAIN,
      WAIT_DONE,
      EMIT,
      FINISH
   } state_e;

   localparam int DW_DEF      = 32;
   localparam int N_IN_L1     = 784;
   localparam int N_OUT_L1    = 10;
   localparam int TMO_CYC_DEF = 64;

   // Address width for a memory of n words; never narrower than one bit
   function automatic int clogW(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/node_addr_gen.sv
// Address generator for the node sequencer: input index i, output index o,
// and the weight address formed as a running base (o*N_IN) plus offset i.
module node_addr_gen
   import node_pkg::*;
#(
   parameter int N_IN  = N_IN_L1,
   parameter int N_OUT = N_OUT_L1,
   parameter int WAW   = clogW(N_IN * N_OUT),
   parameter int XAW   = clogW(N_IN),
   parameter int BAW   = clogW(N_OUT)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           clr_i,
   input  logic           incI_i,
   input  logic           nextO_i,
   output logic [XAW-1:0] iCnt_o,
   output logic [BAW-1:0] oCnt_o,
   output logic [WAW-1:0] wAddr_o,
   output logic           lastI_o,
   output logic           lastO_o
);

   logic [XAW-1:0] iCnt_q;
   logic [BAW-1:0] oCnt_q;
   logic [WAW-1:0] base_q;

   // Counters: clear at pass start, step i while streaming, and on moving to
   // the next output bump o and advance the weight base by one row of N_IN
   always_ff @(posedge clock) begin
      if (reset || clr_i) begin
         iCnt_q <= '0;
         oCnt_q <= '0;
         base_q <= '0;
      end else if (nextO_i) begin
         iCnt_q <= '0;
         oCnt_q <= oCnt_q + 1'b1;
         base_q <= base_q + WAW'(N_IN);
      end else if (incI_i) begin
         iCnt_q <= iCnt_q + 1'b1;
      end
   end

   assign iCnt_o  = iCnt_q;
   assign oCnt_o  = oCnt_q;
   assign wAddr_o = base_q + WAW'(iCnt_q);
   assign lastI_o = (iCnt_q == XAW'(N_IN - 1));
   assign lastO_o = (oCnt_q == BAW'(N_OUT - 1));

endmodule

// File: rtl/node_sequencer.sv
// Upstream sequencer that time-multiplexes one neuron across N_OUT outputs:
// fetches each bias, streams N_IN (weight, input) pairs, collects the relu
// result and offers it on a valid/ready stream.
// Optional feature macro: NODE_TIMEOUT_EN (WAIT_DONE watchdog, sticky err).
module node_sequencer
   import node_pkg::*;
#(
   parameter int N_IN    = N_IN_L1,
   parameter int N_OUT   = N_OUT_L1,
   parameter int DW      = DW_DEF,
   parameter int TMO_CYC = TMO_CYC_DEF,
   localparam int WAW    = clogW(N_IN * N_OUT),
   localparam int XAW    = clogW(N_IN),
   localparam int BAW    = clogW(N_OUT)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic [WAW-1:0] w_addr,
   input  logic [DW-1:0]  w_rdata,
   output logic [XAW-1:0] x_addr,
   input  logic [DW-1:0]  x_rdata,
   output logic [BAW-1:0] b_addr,
   input  logic [DW-1:0]  b_rdata,
   output logic [DW-1:0]  w_node2neuron,
   output logic [DW-1:0]  x_node2neuron,
   output logic [DW-1:0]  b_node2neuron,
   output logic           head_node2neuron,
   input  logic [DW-1:0]  relu_out_neuron2node,
   input  logic           relu_done_neuron2node,
   output logic [DW-1:0]  res_data,
   output logic [BAW-1:0] res_idx,
   output logic           res_valid,
   input  logic           res_ready,
   output logic           err
);

   state_e state_q, state_d;

   logic           clrCnt, incI, nextO, capRes, tmoHit, bLoad;
   logic [XAW-1:0] iCnt;
   logic [BAW-1:0] oCnt;
   logic           lastI, lastO;

   logic           bPhase_q;
   logic           tagValid_q, tagHead_q;
   logic [DW-1:0]  bReg_q;
   logic [DW-1:0]  resData_q;
   logic [BAW-1:0] resIdx_q;
   logic           resValid_q;

   node_addr_gen #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT),
      .WAW   (WAW),
      .XAW   (XAW),
      .BAW   (BAW)
   ) uAddrGen (
      .clock   (clock),
      .reset   (reset),
      .clr_i   (clrCnt),
      .incI_i  (incI),
      .nextO_i (nextO),
      .iCnt_o  (iCnt),
      .oCnt_o  (oCnt),
      .wAddr_o (w_addr),
      .lastI_o (lastI),
      .lastO_o (lastO)
   );

`ifdef NODE_TIMEOUT_EN
   localparam int TW = clogW(TMO_CYC);
   logic [TW-1:0] tmo_q;
   logic          err_q;

   // Watchdog: counts cycles spent in WAIT_DONE; err stays set until reset
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= (state_q == WAIT_DONE) ? tmo_q + 1'b1 : '0;
         if (tmoHit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // State register; reset aborts any pass in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and per-cycle control strobes for counters and capture
   always_comb begin
      state_d = state_q;
      clrCnt  = 1'b0;
      incI    = 1'b0;
      nextO   = 1'b0;
      capRes  = 1'b0;
      tmoHit  = 1'b0;
      bLoad   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               clrCnt  = 1'b1;
               state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            if (bPhase_q) begin
               bLoad   = 1'b1;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (lastI) begin
               state_d = DRAIN;
            end else begin
               incI = 1'b1;
            end
         end
         DRAIN: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (relu_done_neuron2node) begin
               capRes  = 1'b1;
               state_d = EMIT;
            end
`ifdef NODE_TIMEOUT_EN
            else if (tmo_q == TW'(TMO_CYC - 1)) begin
               tmoHit  = 1'b1;
               state_d = EMIT;
            end
`endif
         end
         EMIT: begin
            if (res_ready) begin
               if (lastO) begin
                  state_d = FINISH;
               end else begin
                  nextO   = 1'b1;
                  state_d = LOAD_B;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath registers: two-cycle bias fetch, read tags that travel one cycle
   // behind the issued addresses, and the result holding register
   always_ff @(posedge clock) begin
      if (reset) begin
         bPhase_q   <= 1'b0;
         tagValid_q <= 1'b0;
         tagHead_q  <= 1'b0;
         bReg_q     <= '0;
         resData_q  <= '0;
         resIdx_q   <= '0;
         resValid_q <= 1'b0;
      end else begin
         bPhase_q   <= (state_q == LOAD_B) && !bPhase_q;
         tagValid_q <= (state_q == STREAM);
         tagHead_q  <= (state_q == STREAM) && (iCnt == '0);
         if (bLoad) begin
            bReg_q <= b_rdata;
         end
         if (capRes || tmoHit) begin
            resData_q  <= capRes ? relu_out_neuron2node : '0;
            resIdx_q   <= oCnt;
            resValid_q <= 1'b1;
         end else if ((state_q == EMIT) && res_ready) begin
            resValid_q <= 1'b0;
         end
      end
   end

   assign x_addr           = iCnt;
   assign b_addr           = oCnt;
   assign w_node2neuron    = tagValid_q ? w_rdata : '0;
   assign x_node2neuron    = tagValid_q ? x_rdata : '0;
   assign b_node2neuron    = bReg_q;
   assign head_node2neuron = tagHead_q;
   assign res_data         = resData_q;
   assign res_idx          = resIdx_q;
   assign res_valid        = resValid_q;
   assign busy             = (state_q != IDLE);
   assign done             = (state_q == FINISH);

endmodule

// File: tb/tb_node_sequencer.sv
// Bench for node_sequencer with N_IN=4, N_OUT=2: synchronous memory models,
// a behavioural neuron, and a result scoreboard fed by the stimulus tasks.
module tb_node_sequencer;

   localparam int N_IN    = 4;
   localparam int N_OUT   = 2;
   localparam int DW      = 32;
   localparam int TMO_CYC = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          busy, done;
   logic [2:0]    w_addr;
   logic [1:0]    x_addr;
   logic [0:0]    b_addr;
   logic [DW-1:0] w_rdata, x_rdata, b_rdata;
   logic [DW-1:0] w_node2neuron, x_node2neuron, b_node2neuron;
   logic          head_node2neuron;
   logic [DW-1:0] relu_out_neuron2node;
   logic          relu_done_neuron2node;
   logic [DW-1:0] res_data;
   logic [0:0]    res_idx;
   logic          res_valid, res_ready;
   logic          err;

   node_sequencer #(
      .N_IN    (N_IN),
      .N_OUT   (N_OUT),
      .DW      (DW),
      .TMO_CYC (TMO_CYC)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .start                 (start),
      .busy                  (busy),
      .done                  (done),
      .w_addr                (w_addr),
      .w_rdata               (w_rdata),
      .x_addr                (x_addr),
      .x_rdata               (x_rdata),
      .b_addr                (b_addr),
      .b_rdata               (b_rdata),
      .w_node2neuron         (w_node2neuron),
      .x_node2neuron         (x_node2neuron),
      .b_node2neuron         (b_node2neuron),
      .head_node2neuron      (head_node2neuron),
      .relu_out_neuron2node  (relu_out_neuron2node),
      .relu_done_neuron2node (relu_done_neuron2node),
      .res_data              (res_data),
      .res_idx               (res_idx),
      .res_valid             (res_valid),
      .res_ready             (res_ready),
      .err                   (err)
   );

   always #5 clock = ~clock;

   typedef struct {
      int idx;
      int data;
   } res_t;

   res_t expQ[$];
   int   total = 0;
   int   bad   = 0;

   int   wMem[8];
   int   xMem[4];
   int   bMem[2];

   int   acc = 0, beat = 0, delay = 0, oo = 0, headCount = 0;
   int   doneCount = 0;
   bit   mute = 1'b0;
   bit   spur = 1'b0;
   bit   doneSeenPrev = 1'b0;
   logic          nDone = 1'b0;
   logic [DW-1:0] nOut = '0;

   assign relu_done_neuron2node = nDone | spur;
   assign relu_out_neuron2node  = spur ? 32'd999 : nOut;

   function automatic void check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Synchronous ROM/RAM models with one cycle of read latency
   always @(posedge clock) begin
      w_rdata <= wMem[w_addr];
      x_rdata <= xMem[x_addr];
      b_rdata <= bMem[b_addr];
   end

   // Behavioural neuron: checks every streamed beat against the memory
   // contents, accumulates bias plus dot product, and pulses done 3 cycles later
   always @(negedge clock) begin
      if (reset) begin
         beat  = 0;
         delay = 0;
         nDone = 1'b0;
      end else begin
         nDone = 1'b0;
         if (delay > 0) begin
            delay--;
            if (delay == 0 && !mute) begin
               nDone = 1'b1;
               nOut  = (acc < 0) ? 0 : acc;
            end
         end
         if (beat > 0) begin
            check("headMid", head_node2neuron, 0);
            check("wBeat", w_node2neuron, oo * N_IN + beat);
            check("xBeat", x_node2neuron, xMem[beat]);
            check("bHeld", b_node2neuron, bMem[oo]);
            acc = acc + int'(w_node2neuron) * int'(x_node2neuron);
            beat++;
            if (beat == N_IN) begin
               beat  = 0;
               delay = 3;
            end
         end else if (head_node2neuron) begin
            oo = headCount;
            headCount++;
            check("wHead", w_node2neuron, oo * N_IN);
            check("xHead", x_node2neuron, xMem[0]);
            check("bHead", b_node2neuron, bMem[oo]);
            acc  = int'(b_node2neuron) + int'(w_node2neuron) * int'(x_node2neuron);
            beat = 1;
         end
      end
   end

   // Result monitor: compares each offered result with the scoreboard head,
   // pops on handshake, and tracks done/busy timing
   always @(negedge clock) begin
      if (!reset) begin
         if (doneSeenPrev) begin
            check("busyAfterDone", busy, 0);
         end
         doneSeenPrev = done;
         if (done) begin
            doneCount++;
         end
         if (res_valid) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL extraResult: got idx=%0d data=%0d expected none", res_idx, res_data);
            end else begin
               check("resIdx", res_idx, expQ[0].idx);
               check("resData", res_data, expQ[0].data);
               if (!res_ready) begin
                  check("stallBaddr", b_addr, expQ[0].idx);
                  check("stallHead", head_node2neuron, 0);
               end else begin
                  void'(expQ.pop_front());
               end
            end
         end
      end
   end

   task automatic checkResetValues();
      check("rstBusy", busy, 0);
      check("rstDone", done, 0);
      check("rstHead", head_node2neuron, 0);
      check("rstValid", res_valid, 0);
      check("rstErr", err, 0);
      check("rstWaddr", w_addr, 0);
      check("rstXaddr", x_addr, 0);
      check("rstBaddr", b_addr, 0);
      check("rstWnode", w_node2neuron, 0);
      check("rstXnode", x_node2neuron, 0);
      check("rstBnode", b_node2neuron, 0);
      check("rstResData", res_data, 0);
      check("rstResIdx", res_idx, 0);
   endtask

   task automatic waitHead();
      int cyc = 0;
      while (!head_node2neuron && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      if (!head_node2neuron) begin
         total++;
         bad++;
         $display("[TB] FAIL headTimeout: got no head beat expected one within 100 cycles");
      end
   endtask

   // Runs one layer pass: loads memories, queues the hand-computed results,
   // then drives start and the optional stall/spurious-done disturbances
   task automatic applyStimulus(input int b0, input int b1, input int xv[4],
                                input int exp0, input int exp1,
                                input bit holdStart, input bit spurious, input int stall);
      int cyc = 0;
      bMem[0] = b0;
      bMem[1] = b1;
      for (int k = 0; k < 4; k++) xMem[k] = xv[k];
      headCount = 0;
      expQ.push_back('{0, exp0});
      expQ.push_back('{1, exp1});
      res_ready = (stall == 0);
      @(posedge clock); #1;
      start = 1'b1;
      if (!holdStart) begin
         @(posedge clock); #1;
         start = 1'b0;
      end
      if (spurious) begin
         @(negedge clock);
         waitHead();
         @(posedge clock); #1;
         spur = 1'b1;
         @(posedge clock); #1;
         spur = 1'b0;
      end
      if (stall > 0) begin
         while (!res_valid && cyc < 200) begin
            @(negedge clock);
            cyc++;
         end
         repeat (stall) @(posedge clock);
         #1;
         res_ready = 1'b1;
      end
      cyc = 0;
      while (!done && cyc < 400) begin
         @(negedge clock);
         cyc++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("[TB] FAIL doneTimeout: got no done expected done within 400 cycles");
      end
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   // Settles after a pass and checks pass-level bookkeeping
   task automatic checkOutput(input int doneBase, input int errExp);
      repeat (20) @(negedge clock);
      check("donePulses", doneCount - doneBase, 1);
      check("queueEmpty", expQ.size(), 0);
      check("headsPerPass", headCount, N_OUT);
      check("busyIdle", busy, 0);
      check("errState", err, errExp);
   endtask

   initial begin
      int base;
      for (int k = 0; k < 8; k++) wMem[k] = k;
      for (int k = 0; k < 4; k++) xMem[k] = 0;
      bMem[0] = 0;
      bMem[1] = 0;
      reset     = 1'b1;
      start     = 1'b0;
      res_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkResetValues();
      @(posedge clock); #1;
      reset = 1'b0;

      $display("[TB] single pass, addressing w[k]=k x=1");
      base = doneCount;
      applyStimulus(10, -30, '{1, 1, 1, 1}, 16, 0, 1'b0, 1'b0, 0);
      checkOutput(base, 0);

      $display("[TB] backpressure on first result");
      base = doneCount;
      applyStimulus(10, -30, '{5, 1, 2, 3}, 24, 28, 1'b0, 1'b0, 5);
      checkOutput(base, 0);

      $display("[TB] reset mid-stream then fresh pass");
      bMem[0] = 10;
      bMem[1] = -30;
      headCount = 0;
      expQ.push_back('{0, 24});
      @(posedge clock); #1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      waitHead();
      @(posedge clock); #1;
      reset = 1'b1;
      expQ.delete();
      @(posedge clock);
      @(negedge clock);
      checkResetValues();
      @(posedge clock); #1;
      reset = 1'b0;
      base = doneCount;
      applyStimulus(10, -30, '{5, 1, 2, 3}, 24, 28, 1'b0, 1'b0, 0);
      checkOutput(base, 0);

      $display("[TB] start held high with spurious relu_done");
      base = doneCount;
      applyStimulus(-1, 100, '{2, 2, 2, 2}, 11, 144, 1'b1, 1'b1, 0);
      checkOutput(base, 0);

`ifdef NODE_TIMEOUT_EN
      $display("[TB] watchdog with silent neuron");
      mute = 1'b1;
      base = doneCount;
      applyStimulus(10, -30, '{1, 1, 1, 1}, 0, 0, 1'b0, 1'b0, 0);
      checkOutput(base, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
